// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver (LSB first) with a 2-FF input synchronizer,
// a valid/ready output register and sticky framing-error / overrun flags.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clear_i,
    output logic       busy_o
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

    state_e        state_q, state_d;
    logic          sync_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q;
    logic          valid_q, ferr_q, ovr_q, busy_q, busy_d;
    logic          byte_done, stop_bad;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!rx_s_q) state_d = START;
            START:     if (cnt_q == HALF_M1) state_d = rx_s_q ? IDLE : DATA;
            DATA:      if (cnt_q == FULL_M1 && idx_q == 3'd7) state_d = STOP;
            STOP:      if (cnt_q == FULL_M1) state_d = rx_s_q ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            IDLE, WAIT_HIGH: cnt_d = '0;
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    byte_done = rx_s_q;
                    stop_bad  = !rx_s_q;
                end
            end
            default: cnt_d = '0;
        endcase
        // busy is registered from the next state so it tracks the state register exactly
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= rx_i;
            rx_s_q  <= sync_q;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
        end
    end

    // A completing byte may take the slot that is being consumed in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (byte_done && (!valid_q || ready_i)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            ferr_q <= stop_bad | (ferr_q & ~clear_i);
            ovr_q  <= (byte_done & valid_q & ~ready_i) | (ovr_q & ~clear_i);
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random frames,
// with an expected-byte queue that every accepted byte is checked against.
module tb_uart_rx_core;
    localparam int unsigned N = 8;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic       frame_err_o;
    logic       overrun_o;
    logic       clear_i = 1'b0;
    logic       busy_o;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         rmode = 0;   // 0: ready low, 1: ready high, 2: random ready
    logic [7:0] exp_q[$];

    uart_rx_core #(.CLKS_PER_BIT(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .clear_i    (clear_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_hi);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (N) @(negedge clk);
        end
        rx_i = stop_hi;
        repeat (N) @(negedge clk);
    endtask

    // Consumer: ready is chosen at the negedge, so a handshake happens at the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            case (rmode)
                0:       ready_i = 1'b0;
                1:       ready_i = 1'b1;
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
            if (!rst_i && valid_o && ready_i) begin
                if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
                else check("rx_byte", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] part;

        cyc(3);
        rst_i = 1'b0;
        check("rst_data", {24'h0, data_o}, 32'h0);
        check("rst_valid", valid_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        check("rst_busy", busy_o, 0);
        cyc(2);

        // Single byte, exact latency 3 + N/2 + 9N
        rmode = 0;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk);
                repeat (3 + N / 2 + 9 * N - 1) @(negedge clk);
                check("lat_early", valid_o, 0);
                @(negedge clk);
                check("lat_valid", valid_o, 1);
                check("single_data", {24'h0, data_o}, 32'hA5);
            end
        join
        cyc(20);
        check("single_hold", valid_o, 1);
        check("single_ferr", frame_err_o, 0);
        check("single_ovr", overrun_o, 0);
        rmode = 1;
        cyc(1);
        rmode = 0;
        check("single_drop", valid_o, 0);
        check("single_q", exp_q.size(), 0);

        // Back-to-back with ready tied high
        rmode = 1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        cyc(2 * N);
        check("b2b_q", exp_q.size(), 0);
        check("b2b_ovr", overrun_o, 0);

        // Overrun: second byte dropped, first kept
        rmode = 0;
        cyc(2);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        cyc(2);
        check("ovr_data", {24'h0, data_o}, 32'h12);
        check("ovr_valid", valid_o, 1);
        check("ovr_flag", overrun_o, 1);
        check("ovr_ferr", frame_err_o, 0);
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        check("ovr_clear", overrun_o, 0);
        check("ovr_keep", valid_o, 1);
        rmode = 1;
        cyc(3);
        check("ovr_q", exp_q.size(), 0);
        check("ovr_valid0", valid_o, 0);

        // Framing error followed by a long break
        send_frame(8'h3C, 1'b0);
        check("fe_flag", frame_err_o, 1);
        check("fe_valid", valid_o, 0);
        for (int i = 0; i < 30; i++) begin
            repeat (N) @(negedge clk);
            if (i % 10 == 0) check("fe_busy", busy_o, 1);
        end
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("fe_idle", busy_o, 0);
        repeat (20 * N) @(negedge clk);
        check("fe_nobyte", valid_o, 0);
        check("fe_sticky", frame_err_o, 1);
        cyc(1);
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        check("fe_clear", frame_err_o, 0);

        // Glitch: two-cycle low pulse
        @(negedge clk);
        rx_i = 1'b0;
        repeat (2) @(negedge clk);
        rx_i = 1'b1;
        @(negedge clk);
        check("gl_busy", busy_o, 1);
        repeat (3 * N) @(negedge clk);
        check("gl_idle", busy_o, 0);
        check("gl_valid", valid_o, 0);
        check("gl_ferr", frame_err_o, 0);
        check("gl_ovr", overrun_o, 0);

        // Random bytes, random gaps, random consumer
        rmode = 2;
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            repeat ($urandom_range(0, 3 * N)) @(negedge clk);
        end
        rmode = 1;
        cyc(20);
        check("rnd_q", exp_q.size(), 0);
        check("rnd_ovr", overrun_o, 0);
        check("rnd_ferr", frame_err_o, 0);

        // Reset in the middle of the data bits
        part = 8'h5A;
        @(negedge clk);
        rx_i = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_i = part[i];
            repeat (N) @(negedge clk);
        end
        check("mr_busy", busy_o, 1);
        cyc(1);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        check("mr_data", {24'h0, data_o}, 32'h0);
        check("mr_valid", valid_o, 0);
        check("mr_ferr", frame_err_o, 0);
        check("mr_ovr", overrun_o, 0);
        check("mr_busy0", busy_o, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        cyc(3 * N);
        check("mr_q", exp_q.size(), 0);
        check("mr_ferr2", frame_err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
